// File: rtl/ifu_ibuf.sv
// rtl/ifu_ibuf.sv - IFU instruction buffer with multi-lane in-order delivery
//
// Queues fetch groups of up to FETCH_W instructions in a DEPTH-entry circular
// buffer and presents the oldest LANES entries to the decode lanes. Lanes are
// consumed as a leading run of accepting lanes starting at lane 0.
//
// Optional feature macro: IFU_IBUF_STATS_EN (adds starve/stall counters).
//
// Ports:
//   clk               clock
//   rst               synchronous active-low reset (same effect as flush)
//   flush             discard all buffered instructions
//   fetch_valid       fetch group present
//   fetch_ready       buffer has room for a full FETCH_W group
//   fetch_cnt         instructions in the group (slot 0 oldest)
//   fetch_inst        per-slot instruction words, 32 bits per slot
//   fetch_pc          per-slot PCs, PC_W bits per slot
//   ifu_inst_valid    per-lane valid
//   ifu_inst_allowIn  per-lane accept
//   ifu_inst_data     per-lane instruction word (zero when invalid)
//   ifu_inst_pc       per-lane PC (zero when invalid)
//   ifu_buf_count     occupied entries
//   stat_starve_cnt   cycles with an empty buffer (IFU_IBUF_STATS_EN only)
//   stat_stall_cnt    cycles fetch was blocked (IFU_IBUF_STATS_EN only)

module ifu_ibuf #(
   parameter int LANES   = 4,
   parameter int FETCH_W = 4,
   parameter int DEPTH   = 16,
   parameter int PC_W    = 32,
   localparam int CW     = $clog2(FETCH_W + 1),
   localparam int NW     = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    fetch_valid,
   output logic                    fetch_ready,
   input  logic [CW-1:0]           fetch_cnt,
   input  logic [FETCH_W*32-1:0]   fetch_inst,
   input  logic [FETCH_W*PC_W-1:0] fetch_pc,
   output logic [LANES-1:0]        ifu_inst_valid,
   input  logic [LANES-1:0]        ifu_inst_allowIn,
   output logic [LANES*32-1:0]     ifu_inst_data,
   output logic [LANES*PC_W-1:0]   ifu_inst_pc,
   output logic [NW-1:0]           ifu_buf_count
`ifdef IFU_IBUF_STATS_EN
  ,output logic [31:0]             stat_starve_cnt,
   output logic [31:0]             stat_stall_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]     mem_inst [DEPTH];
   logic [PC_W-1:0] mem_pc   [DEPTH];

   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [NW-1:0]   count;

   logic            enq_acc;
   logic [CW-1:0]   enq_n;
   logic [NW-1:0]   deq_n;
   logic            clear;

   assign clear = !rst || flush;

   // Acceptance looks only at registered occupancy, so a group is never
   // accepted on the strength of a same-cycle dequeue.
   assign fetch_ready   = (NW'(DEPTH) - count) >= NW'(FETCH_W);
   assign enq_acc       = fetch_valid && fetch_ready;
   assign enq_n         = enq_acc ? fetch_cnt : '0;
   assign ifu_buf_count = count;

   // Lane k shows entry rd_ptr+k; pointer arithmetic wraps naturally since
   // DEPTH is a power of two.
   always_comb begin
      ifu_inst_valid = '0;
      ifu_inst_data  = '0;
      ifu_inst_pc    = '0;
      for (int k = 0; k < LANES; k++) begin
         if (count > NW'(k)) begin
            ifu_inst_valid[k]           = 1'b1;
            ifu_inst_data[32*k +: 32]   = mem_inst[rd_ptr + AW'(k)];
            ifu_inst_pc[PC_W*k +: PC_W] = mem_pc[rd_ptr + AW'(k)];
         end
      end
   end

   // In-order drain: stop counting at the first lane that is not both valid
   // and accepting, regardless of what later lanes assert.
   always_comb begin
      logic run;
      deq_n = '0;
      run   = 1'b1;
      for (int k = 0; k < LANES; k++) begin
         if (run && ifu_inst_valid[k] && ifu_inst_allowIn[k]) begin
            deq_n = deq_n + NW'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

   // Storage is not reset; occupancy tracking alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!clear && enq_acc) begin
         for (int i = 0; i < FETCH_W; i++) begin
            if (CW'(i) < fetch_cnt) begin
               mem_inst[wr_ptr + AW'(i)] <= fetch_inst[32*i +: 32];
               mem_pc[wr_ptr + AW'(i)]   <= fetch_pc[PC_W*i +: PC_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(enq_n);
         rd_ptr <= rd_ptr + AW'(deq_n);
         count  <= count + NW'(enq_n) - deq_n;
      end
   end

`ifdef IFU_IBUF_STATS_EN
   always_ff @(posedge clk) begin
      if (clear) begin
         stat_starve_cnt <= '0;
         stat_stall_cnt  <= '0;
      end else begin
         if (count == '0 && stat_starve_cnt != '1) begin
            stat_starve_cnt <= stat_starve_cnt + 32'd1;
         end
         if (fetch_valid && !fetch_ready && stat_stall_cnt != '1) begin
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ifu_ibuf.sv
// tb/tb_ifu_ibuf.sv - self-checking bench for ifu_ibuf against a queue model

module tb_ifu_ibuf;

   localparam int LANES   = 4;
   localparam int FETCH_W = 4;
   localparam int DEPTH   = 16;
   localparam int PC_W    = 32;
   localparam int CW      = $clog2(FETCH_W + 1);
   localparam int NW      = $clog2(DEPTH + 1);

   logic                    clk;
   logic                    rst;
   logic                    flush;
   logic                    fetch_valid;
   logic                    fetch_ready;
   logic [CW-1:0]           fetch_cnt;
   logic [FETCH_W*32-1:0]   fetch_inst;
   logic [FETCH_W*PC_W-1:0] fetch_pc;
   logic [LANES-1:0]        ifu_inst_valid;
   logic [LANES-1:0]        ifu_inst_allowIn;
   logic [LANES*32-1:0]     ifu_inst_data;
   logic [LANES*PC_W-1:0]   ifu_inst_pc;
   logic [NW-1:0]           ifu_buf_count;
`ifdef IFU_IBUF_STATS_EN
   logic [31:0]             stat_starve_cnt;
   logic [31:0]             stat_stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0]     inst;
      logic [PC_W-1:0] pc;
   } ent_t;

   ent_t q[$];

   ifu_ibuf #(
      .LANES(LANES), .FETCH_W(FETCH_W), .DEPTH(DEPTH), .PC_W(PC_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .fetch_valid(fetch_valid),
      .fetch_ready(fetch_ready),
      .fetch_cnt(fetch_cnt),
      .fetch_inst(fetch_inst),
      .fetch_pc(fetch_pc),
      .ifu_inst_valid(ifu_inst_valid),
      .ifu_inst_allowIn(ifu_inst_allowIn),
      .ifu_inst_data(ifu_inst_data),
      .ifu_inst_pc(ifu_inst_pc),
      .ifu_buf_count(ifu_buf_count)
`ifdef IFU_IBUF_STATS_EN
     ,.stat_starve_cnt(stat_starve_cnt),
      .stat_stall_cnt(stat_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      assert (!(fetch_valid && fetch_cnt > CW'(FETCH_W)))
         else $error("illegal fetch_cnt %0d", fetch_cnt);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Queue semantics: flush/reset empties; otherwise pop the accepted leading
   // run and append the accepted group behind whatever remains.
   task automatic model_edge();
      int  n;
      bit  rdy;
      if (!rst || flush) begin
         q.delete();
      end else begin
         rdy = (DEPTH - q.size()) >= FETCH_W;
         n = 0;
         for (int k = 0; k < LANES; k++) begin
            if (k < q.size() && ifu_inst_allowIn[k]) n++;
            else break;
         end
         repeat (n) void'(q.pop_front());
         if (fetch_valid && rdy) begin
            for (int i = 0; i < int'(fetch_cnt); i++) begin
               ent_t e;
               e.inst = fetch_inst[32*i +: 32];
               e.pc   = fetch_pc[PC_W*i +: PC_W];
               q.push_back(e);
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < LANES; k++) begin
         logic        ev;
         logic [31:0] ed;
         logic [31:0] ep;
         ev = k < q.size();
         ed = ev ? q[k].inst : 32'd0;
         ep = ev ? q[k].pc   : 32'd0;
         chk($sformatf("lane%0d_valid", k), 64'(ifu_inst_valid[k]), 64'(ev));
         chk($sformatf("lane%0d_data", k), 64'(ifu_inst_data[32*k +: 32]), 64'(ed));
         chk($sformatf("lane%0d_pc", k), 64'(ifu_inst_pc[PC_W*k +: PC_W]), 64'(ep));
      end
      chk("count", 64'(ifu_buf_count), 64'(q.size()));
      chk("fetch_ready", 64'(fetch_ready), 64'((DEPTH - q.size()) >= FETCH_W));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_beat(input int cnt, input logic [31:0] pc0);
      fetch_valid = 1'b1;
      fetch_cnt   = CW'(cnt);
      for (int i = 0; i < FETCH_W; i++) begin
         fetch_inst[32*i +: 32]   = $urandom;
         fetch_pc[PC_W*i +: PC_W] = pc0 + 32'(4 * i);
      end
   endtask

   initial begin
      rst              = 1'b0;
      flush            = 1'b0;
      fetch_valid      = 1'b0;
      fetch_cnt        = '0;
      fetch_inst       = '0;
      fetch_pc         = '0;
      ifu_inst_allowIn = '0;

      // reset state
      step();
      step();
      chk("rst_count", 64'(ifu_buf_count), 64'd0);
      chk("rst_ready", 64'(fetch_ready), 64'd1);
      chk("rst_valid", 64'(ifu_inst_valid), 64'd0);
      chk("rst_pc", 64'(ifu_inst_pc), 64'd0);
      rst = 1'b1;
`ifdef IFU_IBUF_STATS_EN
      repeat (5) step();
      chk("stat_starve", 64'(stat_starve_cnt), 64'd5);
`endif

      // single beat, full drain
      set_beat(4, 32'h100);
      ifu_inst_allowIn = 4'hF;
      step();
      fetch_valid = 1'b0;
      chk("beat_valid", 64'(ifu_inst_valid), 64'hF);
      for (int k = 0; k < LANES; k++)
         chk($sformatf("beat_pc%0d", k), 64'(ifu_inst_pc[PC_W*k +: PC_W]), 64'(32'h100 + 4*k));
      step();
      chk("drain_count", 64'(ifu_buf_count), 64'd0);
      chk("drain_valid", 64'(ifu_inst_valid), 64'd0);

      // partial drain: lane 1 refuses, lanes 2/3 must not be consumed
      ifu_inst_allowIn = 4'h0;
      set_beat(4, 32'h100);
      step();
      fetch_valid = 1'b0;
      ifu_inst_allowIn = 4'b1101;
      step();
      chk("partial_count", 64'(ifu_buf_count), 64'd3);
      chk("partial_pc0", 64'(ifu_inst_pc[PC_W-1:0]), 64'h104);
      ifu_inst_allowIn = 4'hF;
      step();
      chk("partial_empty", 64'(ifu_buf_count), 64'd0);

      // fill to full, blocked beats, then ready returns a cycle after drain
      ifu_inst_allowIn = 4'h0;
      for (int b = 0; b < 4; b++) begin
         set_beat(4, 32'h300 + 32'(16 * b));
         step();
      end
      chk("full_count", 64'(ifu_buf_count), 64'd16);
      chk("full_ready", 64'(fetch_ready), 64'd0);
      set_beat(4, 32'h400);
      repeat (3) step();
      chk("full_reject", 64'(ifu_buf_count), 64'd16);
`ifdef IFU_IBUF_STATS_EN
      chk("stat_stall", 64'(stat_stall_cnt), 64'd3);
`endif
      fetch_valid = 1'b0;
      ifu_inst_allowIn = 4'hF;
      step();
      chk("refill_count", 64'(ifu_buf_count), 64'd12);
      chk("refill_ready", 64'(fetch_ready), 64'd1);
      repeat (3) step();
      chk("fill_empty", 64'(ifu_buf_count), 64'd0);

      // wrap: move both pointers to 14, then a group spanning entries 14..1
      flush = 1'b1;
      step();
      flush = 1'b0;
      ifu_inst_allowIn = 4'hF;
      repeat (14) begin
         set_beat(1, 32'h500);
         step();
      end
      fetch_valid = 1'b0;
      step();
      chk("wrap_pre_empty", 64'(ifu_buf_count), 64'd0);
      ifu_inst_allowIn = 4'h0;
      set_beat(4, 32'h200);
      step();
      fetch_valid = 1'b0;
      for (int k = 0; k < LANES; k++)
         chk($sformatf("wrap_pc%0d", k), 64'(ifu_inst_pc[PC_W*k +: PC_W]), 64'(32'h200 + 4*k));
      ifu_inst_allowIn = 4'hF;
      step();
      chk("wrap_empty", 64'(ifu_buf_count), 64'd0);

      // flush with a concurrent beat: beat is lost
      ifu_inst_allowIn = 4'h0;
      set_beat(4, 32'h600);
      step();
      set_beat(4, 32'h610);
      step();
      chk("pre_flush_count", 64'(ifu_buf_count), 64'd8);
      set_beat(4, 32'h700);
      flush = 1'b1;
      step();
      flush = 1'b0;
      fetch_valid = 1'b0;
      chk("flush_count", 64'(ifu_buf_count), 64'd0);
      chk("flush_valid", 64'(ifu_inst_valid), 64'd0);
      chk("flush_ready", 64'(fetch_ready), 64'd1);
      step();
      chk("flush_lost", 64'(ifu_buf_count), 64'd0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(0, 199) != 0);
         flush = ($urandom_range(0, 63) == 0);
         fetch_valid = ($urandom_range(0, 2) != 0);
         fetch_cnt   = CW'($urandom_range(0, FETCH_W));
         for (int i = 0; i < FETCH_W; i++) begin
            fetch_inst[32*i +: 32]   = $urandom;
            fetch_pc[PC_W*i +: PC_W] = $urandom;
         end
         case ($urandom_range(0, 3))
            0:       ifu_inst_allowIn = LANES'($urandom);
            1:       ifu_inst_allowIn = '0;
            default: ifu_inst_allowIn = '1;
         endcase
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
